instr_fetch_unit: RTL and testbench

//   Instruction sequencer feeding the opcode decoder of the 8-bit CPU.
//   - Owns the PC and fetches 16-bit words from instruction memory over a req/valid handshake.
//   - Splits each word into opcode/rd/rs/imm and presents it to decode/execute with valid/ready.
//   - Consumes the decoder's pc_write and the ALU zero flag to resolve JMP/BEQ redirects.

---
 rtl/instr_fetch_unit.sv | 91 +++++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over req/valid,
// splits them into fields and issues them to decode/execute.
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [7:0]         imm,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               pc_write,
    input  logic               zero_flag,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic [15:0]        retired
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALTED
    } state_t;

    state_t state, state_d;

    logic capture;
    logic accept;
    logic taken;
    logic [ADDR_W-1:0] pc_d;

    assign capture   = (state == FETCH) && imem_valid;
    assign accept    = (state == ISSUE) && instr_ready;
    assign imem_addr = pc;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = FETCH;
            FETCH:   if (imem_valid) state_d = ISSUE;
            ISSUE:   if (instr_ready) state_d = halt ? HALTED : FETCH;
            HALTED:  if (!halt) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // JMP always redirects; BEQ only when the ALU reports zero
    always_comb begin
        taken = pc_write &&
                ((opcode == 4'b1000) || ((opcode == 4'b1001) && zero_flag));
        pc_d  = taken ? ADDR_W'(imm) : pc + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= ADDR_W'(RESET_PC);
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            opcode      <= 4'd0;
            rd          <= 2'd0;
            rs          <= 2'd0;
            imm         <= 8'd0;
            retired     <= 16'd0;
        end else begin
            state       <= state_d;
            imem_req    <= (state_d == FETCH);
            instr_valid <= (state_d == ISSUE);
            if (capture) begin
                opcode <= imem_rdata[15:12];
                rd     <= imem_rdata[11:10];
                rs     <= imem_rdata[9:8];
                imm    <= imem_rdata[7:0];
            end
            if (accept) begin
                pc      <= pc_d;
                retired <= retired + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table,
// hand-written corner sequences and randomized traffic vs a reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic [3:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pc_write = 1'b0;
    logic        zero_flag = 1'b0;
    logic        halt = 1'b0;
    logic [7:0]  pc;
    logic [15:0] retired;

    instr_fetch_unit #(
        .ADDR_W  (8),
        .INSTR_W (16),
        .RESET_PC(8'h10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .imm        (imm),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc_write   (pc_write),
        .zero_flag  (zero_flag),
        .halt       (halt),
        .pc         (pc),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_pc;
    logic [15:0] exp_ret;

    typedef struct {
        logic [15:0] word;
        int          wait_n;
        int          stall_n;
        logic        pw;
        logic        zf;
        logic        hlt;
        logic [7:0]  next_pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: next PC from the branch rules with plain arithmetic
    function automatic logic [7:0] ref_next(input logic [7:0] cur,
                                            input logic [15:0] w,
                                            input logic pw,
                                            input logic zf);
        int op;
        op = int'(w >> 12);
        if (pw && (op == 8 || (op == 9 && zf)))
            return w[7:0];
        return 8'((int'(cur) + 1) % 256);
    endfunction

    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: imem_req never rose");
        end
    endtask

    // One fetch+issue transaction; caller sits on a negedge
    task automatic do_instr(input logic [15:0] w, input int wait_n,
                            input int stall_n, input logic pw,
                            input logic zf, input logic hlt,
                            input logic [7:0] nxt);
        wait_req();
        chk("fetch_addr", 32'(imem_addr), 32'(exp_pc));
        for (int i = 0; i < wait_n; i++) begin
            imem_valid = 1'b0;
            @(negedge clk);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", 32'(imem_addr), 32'(exp_pc));
            chk("wait_ivalid", 32'(instr_valid), 32'd0);
        end
        imem_valid = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 16'hDEAD;
        chk("issue_valid", 32'(instr_valid), 32'd1);
        chk("issue_req", 32'(imem_req), 32'd0);
        chk("fields", {16'h0, opcode, rd, rs, imm}, {16'h0, w});
        chk("issue_pc", 32'(pc), 32'(exp_pc));
        for (int i = 0; i < stall_n; i++) begin
            pc_write  = ~pw;
            zero_flag = ~zf;
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_fields", {16'h0, opcode, rd, rs, imm}, {16'h0, w});
            chk("stall_ret", 32'(retired), 32'(exp_ret));
        end
        instr_ready = 1'b1;
        pc_write    = pw;
        zero_flag   = zf;
        halt        = hlt;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_write    = 1'b0;
        zero_flag   = 1'b0;
        exp_ret     = exp_ret + 16'd1;
        exp_pc      = ref_next(exp_pc, w, pw, zf);
        chk("model_vs_table", 32'(exp_pc), 32'(nxt));
        chk("drop_valid", 32'(instr_valid), 32'd0);
        chk("retired", 32'(retired), 32'(exp_ret));
        chk("next_pc", 32'(pc), 32'(exp_pc));
        chk("next_req", 32'(imem_req), hlt ? 32'd0 : 32'd1);
    endtask

    task automatic leave_halt();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
        end
        halt = 1'b0;
        @(negedge clk);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'(exp_pc));
    endtask

    initial begin
        vecs[0] = '{16'h0123, 0, 0, 1'b0, 1'b0, 1'b0, 8'h11};
        vecs[1] = '{16'h8040, 0, 0, 1'b1, 1'b0, 1'b0, 8'h40};
        vecs[2] = '{16'h9055, 0, 0, 1'b1, 1'b0, 1'b0, 8'h41};
        vecs[3] = '{16'h9055, 1, 1, 1'b1, 1'b1, 1'b0, 8'h55};
        vecs[4] = '{16'h1234, 3, 4, 1'b0, 1'b0, 1'b0, 8'h56};
        vecs[5] = '{16'h80FF, 0, 0, 1'b1, 1'b0, 1'b0, 8'hFF};
        vecs[6] = '{16'h2000, 0, 0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{16'h8077, 0, 2, 1'b0, 1'b1, 1'b0, 8'h01};
        vecs[8] = '{16'h9033, 2, 0, 1'b0, 1'b1, 1'b0, 8'h02};
        vecs[9] = '{16'h3456, 1, 1, 1'b0, 1'b0, 1'b1, 8'h03};

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_ret", 32'(retired), 32'd0);
        chk("rst_pc", 32'(pc), 32'h10);
        chk("rst_fields", {16'h0, opcode, rd, rs, imm}, 32'd0);

        rst_n = 1'b1;
        chk("idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'h10);
        exp_pc  = 8'h10;
        exp_ret = 16'h0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].hlt) halt = 1'b1;
            do_instr(vecs[i].word, vecs[i].wait_n, vecs[i].stall_n,
                     vecs[i].pw, vecs[i].zf, vecs[i].hlt, vecs[i].next_pc);
        end
        leave_halt();

        // retired wraps from 0xFFFF to 0
        force dut.retired = 16'hFFFF;
        #1;
        release dut.retired;
        exp_ret = 16'hFFFF;
        do_instr(16'h4100, 0, 0, 1'b0, 1'b0, 1'b0, 8'h04);
        chk("ret_wrap", 32'(retired), 32'd0);

        // async reset while an instruction is presented
        wait_req();
        imem_valid = 1'b1;
        imem_rdata = 16'h5ABC;
        @(negedge clk);
        imem_valid = 1'b0;
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_ret", 32'(retired), 32'd0);
        chk("arst_pc", 32'(pc), 32'h10);
        chk("arst_fields", {16'h0, opcode, rd, rs, imm}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_pc  = 8'h10;
        exp_ret = 16'h0;
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            logic [15:0] w;
            logic        pw, zf, hl;
            logic [7:0]  nxt;
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                w[15:12] = 4'($urandom_range(8, 9));
            pw  = 1'($urandom);
            zf  = 1'($urandom);
            hl  = ($urandom_range(0, 7) == 0);
            nxt = ref_next(exp_pc, w, pw, zf);
            halt = ($urandom_range(0, 3) == 0);
            do_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                     pw, zf, hl, nxt);
            if (hl) leave_halt();
            else halt = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
